// File: rtl/music_sequencer.sv
// Beat sequencer for a song held in an external ROM: walks beat indices at a
// selectable tempo and registers the addressed tone for the note generator.
module music_sequencer #(
    parameter int TONE_W    = 32,
    parameter int BEAT_W    = 8,
    parameter int SONG_LEN  = 118,
    parameter int BEAT_DIV  = 12500000,
    parameter int MUTE_TONE = 20000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [1:0]        tempo_sel,
    output logic [BEAT_W-1:0] rom_addr,
    input  logic [TONE_W-1:0] rom_tone,
    output logic [TONE_W-1:0] tone,
    output logic [BEAT_W-1:0] beat_num,
    output logic              playing,
    output logic              song_done
);

    // Divider must reach 2*BEAT_DIV-1 at half speed.
    localparam int DIV_W = $clog2(2 * BEAT_DIV + 1);

    localparam logic [DIV_W-1:0]  LAST_NORM = DIV_W'(BEAT_DIV - 1);
    localparam logic [DIV_W-1:0]  LAST_HALF = DIV_W'(2 * BEAT_DIV - 1);
    localparam logic [DIV_W-1:0]  LAST_DBL  = DIV_W'(BEAT_DIV / 2 - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SONG_LEN - 1);
    localparam logic [TONE_W-1:0] MUTE      = TONE_W'(MUTE_TONE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   divider, divider_nxt;
    logic [DIV_W-1:0]   divider_last;
    logic [BEAT_W-1:0]  beat_nxt;
    logic [TONE_W-1:0]  tone_nxt;
    logic               done_nxt;

    assign rom_addr = beat_num;
    assign playing  = (state == PLAY);

    always_comb begin
        case (tempo_sel)
            2'b01:   divider_last = LAST_HALF;
            2'b10:   divider_last = LAST_DBL;
            default: divider_last = LAST_NORM;
        endcase
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat_num;
        divider_nxt = divider;
        tone_nxt    = MUTE;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                beat_nxt    = '0;
                divider_nxt = '0;
                if (start && !stop)
                    state_nxt = PLAY;
            end
            PLAY: begin
                if (stop) begin
                    state_nxt   = IDLE;
                    beat_nxt    = '0;
                    divider_nxt = '0;
                end else if (start) begin
                    beat_nxt    = '0;
                    divider_nxt = '0;
                    tone_nxt    = rom_tone;
                end else if (pause) begin
                    state_nxt = PAUSE;
                end else begin
                    tone_nxt = rom_tone;
                    // >= rather than == so a tempo switch to a shorter beat never overshoots.
                    if (divider >= divider_last) begin
                        divider_nxt = '0;
                        if (beat_num == LAST_BEAT) begin
                            done_nxt = 1'b1;
                            beat_nxt = '0;
                            if (!loop_en) begin
                                state_nxt = IDLE;
                                tone_nxt  = MUTE;
                            end
                        end else begin
                            beat_nxt = beat_num + BEAT_W'(1);
                        end
                    end else begin
                        divider_nxt = divider + DIV_W'(1);
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_nxt   = IDLE;
                    beat_nxt    = '0;
                    divider_nxt = '0;
                end else if (start) begin
                    state_nxt = PLAY;
                end
            end
            default: begin
                state_nxt   = IDLE;
                beat_nxt    = '0;
                divider_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            divider   <= '0;
            beat_num  <= '0;
            tone      <= MUTE;
            song_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            divider   <= divider_nxt;
            beat_num  <= beat_nxt;
            tone      <= tone_nxt;
            song_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with a 4-beat song, 4 cycles per beat,
// and a ROM model returning 100 + address.
module tb_music_sequencer;

    localparam int          TONE_W = 32;
    localparam int          BEAT_W = 8;
    localparam logic [31:0] MUTE   = 32'd20000;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              pause;
    logic              stop;
    logic              loop_en;
    logic [1:0]        tempo_sel;
    logic [BEAT_W-1:0] rom_addr;
    logic [TONE_W-1:0] rom_tone;
    logic [TONE_W-1:0] tone;
    logic [BEAT_W-1:0] beat_num;
    logic              playing;
    logic              song_done;

    int errors = 0;
    int checks = 0;

    music_sequencer #(
        .TONE_W   (TONE_W),
        .BEAT_W   (BEAT_W),
        .SONG_LEN (4),
        .BEAT_DIV (4),
        .MUTE_TONE(20000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .loop_en  (loop_en),
        .tempo_sel(tempo_sel),
        .rom_addr (rom_addr),
        .rom_tone (rom_tone),
        .tone     (tone),
        .beat_num (beat_num),
        .playing  (playing),
        .song_done(song_done)
    );

    assign rom_tone = 32'd100 + {24'd0, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [7:0]  exp_beat;
        logic [31:0] exp_tone;
        logic        exp_playing;
        logic        exp_done;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t row(logic s, logic [7:0] b, logic [31:0] t, logic p, logic d);
        vec_t v;
        v.start       = s;
        v.exp_beat    = b;
        v.exp_tone    = t;
        v.exp_playing = p;
        v.exp_done    = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cmd(input logic s, input logic p, input logic t);
        start = s;
        pause = p;
        stop  = t;
        tick();
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic expect_all(input string name, input logic [7:0] b, input logic [31:0] t,
                              input logic p, input logic d);
        check({name, ".beat"},    {24'd0, beat_num}, {24'd0, b});
        check({name, ".tone"},    tone, t);
        check({name, ".playing"}, {31'd0, playing}, {31'd0, p});
        check({name, ".done"},    {31'd0, song_done}, {31'd0, d});
    endtask

    initial begin
        // Full song at normal tempo, no loop: row k is the state after the k-th edge,
        // edge 0 being the one that samples start.
        vecs[0]  = row(1'b1, 8'd0, MUTE,   1'b1, 1'b0);
        vecs[1]  = row(1'b0, 8'd0, 32'd100, 1'b1, 1'b0);
        vecs[2]  = row(1'b0, 8'd0, 32'd100, 1'b1, 1'b0);
        vecs[3]  = row(1'b0, 8'd0, 32'd100, 1'b1, 1'b0);
        vecs[4]  = row(1'b0, 8'd1, 32'd100, 1'b1, 1'b0);
        vecs[5]  = row(1'b0, 8'd1, 32'd101, 1'b1, 1'b0);
        vecs[6]  = row(1'b0, 8'd1, 32'd101, 1'b1, 1'b0);
        vecs[7]  = row(1'b0, 8'd1, 32'd101, 1'b1, 1'b0);
        vecs[8]  = row(1'b0, 8'd2, 32'd101, 1'b1, 1'b0);
        vecs[9]  = row(1'b0, 8'd2, 32'd102, 1'b1, 1'b0);
        vecs[10] = row(1'b0, 8'd2, 32'd102, 1'b1, 1'b0);
        vecs[11] = row(1'b0, 8'd2, 32'd102, 1'b1, 1'b0);
        vecs[12] = row(1'b0, 8'd3, 32'd102, 1'b1, 1'b0);
        vecs[13] = row(1'b0, 8'd3, 32'd103, 1'b1, 1'b0);
        vecs[14] = row(1'b0, 8'd3, 32'd103, 1'b1, 1'b0);
        vecs[15] = row(1'b0, 8'd3, 32'd103, 1'b1, 1'b0);
        vecs[16] = row(1'b0, 8'd0, MUTE,   1'b0, 1'b1);
        vecs[17] = row(1'b0, 8'd0, MUTE,   1'b0, 1'b0);

        rst_n     = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        loop_en   = 1'b0;
        tempo_sel = 2'b00;
        tick_n(2);
        expect_all("reset", 8'd0, MUTE, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_n(3);
        expect_all("idle_after_release", 8'd0, MUTE, 1'b0, 1'b0);

        cmd(1'b0, 1'b1, 1'b0);
        expect_all("pause_in_idle", 8'd0, MUTE, 1'b0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            start = vecs[i].start;
            tick();
            start = 1'b0;
            expect_all($sformatf("song[%0d]", i), vecs[i].exp_beat, vecs[i].exp_tone,
                       vecs[i].exp_playing, vecs[i].exp_done);
            check($sformatf("song[%0d].rom_addr", i), {24'd0, rom_addr}, {24'd0, vecs[i].exp_beat});
        end

        // Looping: wrap to beat 0 with a done pulse while staying in PLAY.
        loop_en = 1'b1;
        cmd(1'b1, 1'b0, 1'b0);
        tick_n(15);
        expect_all("loop_last", 8'd3, 32'd103, 1'b1, 1'b0);
        tick();
        expect_all("loop_wrap", 8'd0, 32'd103, 1'b1, 1'b1);
        tick();
        expect_all("loop_after", 8'd0, 32'd100, 1'b1, 1'b0);

        // Restart from PLAY: back to beat 0, divider 0.
        tick_n(8);
        check("pre_restart.beat", {24'd0, beat_num}, 32'd2);
        cmd(1'b1, 1'b0, 1'b0);
        expect_all("restart", 8'd0, 32'd102, 1'b1, 1'b0);
        tick_n(3);
        check("restart_hold.beat", {24'd0, beat_num}, 32'd0);
        tick();
        check("restart_adv.beat", {24'd0, beat_num}, 32'd1);

        // Pause at beat 2 divider 1, wait, resume.
        loop_en = 1'b0;
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        tick_n(9);
        check("pre_pause.beat", {24'd0, beat_num}, 32'd2);
        cmd(1'b0, 1'b1, 1'b0);
        expect_all("paused", 8'd2, MUTE, 1'b0, 1'b0);
        tick_n(10);
        expect_all("paused_hold", 8'd2, MUTE, 1'b0, 1'b0);
        cmd(1'b1, 1'b0, 1'b0);
        expect_all("resume0", 8'd2, MUTE, 1'b1, 1'b0);
        tick_n(2);
        expect_all("resume2", 8'd2, 32'd102, 1'b1, 1'b0);
        tick();
        check("resume3.beat", {24'd0, beat_num}, 32'd3);

        // Stop together with start at the last-beat advance: IDLE, no done pulse.
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        tick_n(15);
        check("pre_stop.beat", {24'd0, beat_num}, 32'd3);
        cmd(1'b1, 1'b0, 1'b1);
        expect_all("stop_start", 8'd0, MUTE, 1'b0, 1'b0);
        tick();
        expect_all("stop_start_after", 8'd0, MUTE, 1'b0, 1'b0);

        // Half speed: 8 cycles per beat.
        tempo_sel = 2'b01;
        cmd(1'b1, 1'b0, 1'b0);
        tick_n(7);
        check("half7.beat", {24'd0, beat_num}, 32'd0);
        tick();
        check("half8.beat", {24'd0, beat_num}, 32'd1);

        // Double speed: 2 cycles per beat.
        cmd(1'b0, 1'b0, 1'b1);
        tempo_sel = 2'b10;
        cmd(1'b1, 1'b0, 1'b0);
        tick();
        check("dbl1.beat", {24'd0, beat_num}, 32'd0);
        tick();
        check("dbl2.beat", {24'd0, beat_num}, 32'd1);
        tick_n(2);
        check("dbl4.beat", {24'd0, beat_num}, 32'd2);

        // Asynchronous reset mid-PLAY at beat 2 takes effect before the next edge.
        cmd(1'b0, 1'b0, 1'b1);
        tempo_sel = 2'b00;
        cmd(1'b1, 1'b0, 1'b0);
        tick_n(9);
        check("pre_reset.beat", {24'd0, beat_num}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        expect_all("async_reset", 8'd0, MUTE, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_n(5);
        expect_all("post_reset_idle", 8'd0, MUTE, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 SHALL have parameter TONE_W, default 32, tone word width in Hz.
REQ-002 SHALL have parameter BEAT_W, default 8, beat index width.
REQ-003 SHALL have parameter SONG_LEN, default 118, beats per song (2..2^BEAT_W).
REQ-004 SHALL have parameter BEAT_DIV, default 12500000, clk cycles per beat at normal tempo (>=2).
REQ-005 SHALL have parameter MUTE_TONE, default 20000, tone value meaning silence.
REQ-006 SHALL have ports, one per line, clock and reset first:
  clk  input  1  single system clock, rising edge
  rst_n  input  1  asynchronous active-low reset
  start  input  1  one-cycle command: play from beat 0, or resume from pause
  pause  input  1  one-cycle command: freeze playback
  stop  input  1  one-cycle command: abort to idle
  loop_en  input  1  level: wrap to beat 0 after last beat
  tempo_sel  input  2  00 normal, 01 half speed, 10 double speed, 11 normal
  rom_addr  output  BEAT_W  combinational, equals beat_num
  rom_tone  input  TONE_W  tone from external song ROM at rom_addr, valid same cycle
  tone  output  TONE_W  registered tone to note generator
  beat_num  output  BEAT_W  current beat index
  playing  output  1  high in PLAY state
  song_done  output  1  one-cycle pulse on completion of last beat

Function
REQ-007 SHALL implement states IDLE, PLAY, PAUSE in one registered state machine.
REQ-008 Command priority when asserted together SHALL be stop > start > pause.
REQ-009 IDLE: beat_num=0, divider=0, tone=MUTE_TONE, playing=0; start -> PLAY with beat_num=0, divider=0.
REQ-010 PLAY: tone SHALL be registered from rom_tone each cycle (one-cycle latency from beat_num change to tone change).
REQ-011 Beat period P SHALL be BEAT_DIV (00/11), 2*BEAT_DIV (01), floor(BEAT_DIV/2) (10); divider width sized for 2*BEAT_DIV.
REQ-012 PLAY: divider increments each cycle; when divider >= P-1 it SHALL clear and the beat SHALL advance on that edge; tempo change takes effect immediately via this compare.
REQ-013 Beat advance with beat_num < SONG_LEN-1: beat_num+1.
REQ-014 Beat advance with beat_num = SONG_LEN-1: song_done pulses 1 cycle; loop_en=1 -> beat_num=0, stay PLAY; loop_en=0 -> IDLE (beat_num=0, tone=MUTE_TONE next cycle).
REQ-015 start in PLAY SHALL restart: beat_num=0, divider=0, no song_done.
REQ-016 pause in PLAY -> PAUSE: beat_num and divider hold, tone=MUTE_TONE, playing=0.
REQ-017 start in PAUSE -> PLAY resuming at held beat_num and divider; pause in PAUSE/IDLE ignored.
REQ-018 stop in PLAY or PAUSE -> IDLE with IDLE values next cycle, no song_done.
REQ-019 song_done SHALL never assert outside a last-beat advance in PLAY.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, beat_num=0, divider=0, tone=MUTE_TONE, playing=0, song_done=0, including mid-playback.
REQ-021 Release of rst_n SHALL require start to begin playback.

Verification (BEAT_DIV=4, SONG_LEN=4, ROM tone = 100+addr)
REQ-022 Reset mid-PLAY at beat 2 -> same cycle tone=20000, beat_num=0, playing=0.
REQ-023 start, loop_en=0, tempo 00 -> beat_num 0,1,2,3 each 4 cycles, tone 100..103 lagging 1 cycle, song_done pulse at cycle 16, then IDLE, tone=20000.
REQ-024 loop_en=1 -> after beat 3, beat_num=0, song_done 1-cycle pulse, playing stays 1.
REQ-025 pause at beat 2 divider 1, wait 10 cycles, start -> tone 20000 during pause, beat 3 reached 3 cycles after resume.
REQ-026 tempo_sel 01 -> 8 cycles per beat; 10 -> 2 cycles per beat.
REQ-027 stop and start same cycle in PLAY -> IDLE, beat_num=0, no song_done.
